muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 clk  in  1  core clock; all state updates on the rising edge.
REQ-002 reset_n  in  1  reset; synchronous and active-low (clears state on a rising clk edge while low).
REQ-003 start_mult  in  1  MULT/MULTU issue from the control unit.
REQ-004 start_div  in  1  DIV/DIVU issue.
REQ-005 is_signed  in  1  1 = MULT/DIV, 0 = MULTU/DIVU; sampled with the start signal.
REQ-006 rs_val  in  32  multiplicand or dividend.
REQ-007 rt_val  in  32  multiplier or divisor.
REQ-008 mfhi_sel  in  1  core requests HI this cycle.
REQ-009 mflo_sel  in  1  core requests LO this cycle.
REQ-010 hi  out  32  HI register; remainder for divide.
REQ-011 lo  out  32  LO register; quotient for divide.
REQ-012 busy  out  1  operation in flight.
REQ-013 stall  out  1  combinational; core must hold the PC and the instruction.
REQ-014 done  out  1  one-cycle pulse when HI/LO commit.

Function
REQ-015 States: IDLE, CALC, FIXUP.
- IDLE->CALC on an accepted start.
- CALC->FIXUP when the iteration counter reaches 31.
- FIXUP->IDLE unconditionally.
REQ-016 Start acceptance:
- A start is accepted only in IDLE.
- At acceptance, latch rs_val, rt_val, is_signed and the op, and clear the 6-bit counter.
REQ-017 If start_mult and start_div are both high, MULT wins; start_div is dropped.
REQ-018 Signed ops convert operands to magnitudes at acceptance and record the result signs:
- product sign = rs[31]^rt[31];
- remainder sign = rs[31].
REQ-019 CALC performs one iteration per cycle for exactly 32 cycles:
- multiply: shift-add;
- divide: restoring shift-subtract;
- 64-bit working accumulator.
REQ-020 FIXUP applies two's-complement sign correction where needed, then writes hi/lo and pulses done in the same cycle.
REQ-021 Latency: a start sampled at edge N gives hi/lo updated and done=1 at edge N+33; busy is high from edge N+1 through edge N+33.
REQ-022 hi/lo hold their previous values throughout CALC; partial results are never visible.
REQ-023 stall = busy & (mfhi_sel | mflo_sel | start_mult | start_div).
- A start while busy is ignored, not queued.
- stall drops in the cycle after done.
REQ-024 Divide by zero:
- no trap and no hang; full 33-cycle latency;
- LO = 0xFFFFFFFF, HI = rs_val.
REQ-025 Signed overflow 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0x00000000.
REQ-026 MULT/MULTU: HI = product[63:32], LO = product[31:0].

Reset
REQ-027 reset_n low at any clk edge:
- state = IDLE, counter = 0;
- hi = lo = 0;
- busy = stall = done = 0 after that edge;
- any operation in flight is discarded.
REQ-028 A start asserted during the reset cycle is not accepted.

Structure
REQ-029 Shared package muldiv_pkg holds:
- state enum {IDLE, CALC, FIXUP};
- op encoding {OP_MULT, OP_DIV};
- constant MD_ITER = 32;
- constants DIV0_LO = 32'hFFFFFFFF, OVF_LO = 32'h80000000.
REQ-030 One sub-module, muldiv_step: combinational single iteration (op, accumulator, operand in -> accumulator out); the FSM, counter and HI/LO registers stay in muldiv_sequencer.

Verification
REQ-031 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001, done exactly 33 cycles after the start edge.
REQ-032 MULT -3 x 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; then DIV -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
REQ-033 DIVU 5 / 0 -> LO = 0xFFFFFFFF, HI = 0x00000005, busy clears; DIV 0x80000000 / -1 -> LO = 0x80000000, HI = 0.
REQ-034 mflo_sel at cycle 10 of a MULT:
- stall = 1 until done, 0 the next cycle;
- LO holds the old value until commit;
- start_div at cycle 12 is ignored.
REQ-035 reset_n low at cycle 15 of a DIV -> next edge: IDLE, hi = lo = 0, busy = 0, no done pulse; a new MULT 2 x 3 then yields LO = 6.
REQ-036 start_mult and start_div together (rs = 6, rt = 3) -> multiply performed: LO = 0x12, HI = 0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_t;

  localparam int          MD_ITER = 32;
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_LO  = 32'h8000_0000;

  // Two's-complement magnitude; a no-op when the operand is treated as unsigned.
  function automatic logic [31:0] md_mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring shift-subtract divide.
module muldiv_step
  import muldiv_pkg::*;
(
  input  op_t         op_i,
  input  logic [63:0] acc_i,
  input  logic [31:0] operand_i,
  output logic [63:0] acc_o
);

  logic [32:0] add_sum;
  logic [33:0] sub_diff;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  // Divide:   acc = {partial remainder, remaining dividend / quotient bits};
  // the remainder is shifted into a 33-bit window so divisors >= 2^31 work.
  assign add_sum  = {1'b0, acc_i[63:32]} + {1'b0, operand_i};
  assign sub_diff = {1'b0, acc_i[63:31]} - {2'b00, operand_i};

  always_comb begin
    acc_o = {acc_i[62:0], 1'b0};
    if (op_i == OP_MULT) begin
      if (acc_i[0]) acc_o = {add_sum, acc_i[31:1]};
      else          acc_o = {1'b0, acc_i[63:1]};
    end else begin
      if (!sub_diff[33]) acc_o = {sub_diff[31:0], acc_i[30:0], 1'b1};
      else               acc_o = {acc_i[62:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers and core stall.
module muldiv_sequencer
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic        is_signed,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mfhi_sel,
  input  logic        mflo_sel,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output state_t      dbg_state
);

  state_t      state_q;
  op_t         op_q;
  logic [5:0]  cnt_q;
  logic [63:0] acc_q;
  logic [63:0] acc_d;
  logic [31:0] operand_q;
  logic [31:0] rs_q;
  logic        prod_neg_q;
  logic        quo_neg_q;
  logic        rem_neg_q;
  logic        div0_q;
  logic        ovf_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;

  logic        accept;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  // busy_q covers the commit cycle too, so the extra IDLE cycle with done
  // high still blocks a new start while the core is being stalled.
  assign accept = (state_q == IDLE) && !busy_q && (start_mult || start_div);

  muldiv_step u_step (
    .op_i      (op_q),
    .acc_i     (acc_q),
    .operand_i (operand_q),
    .acc_o     (acc_d)
  );

  always_comb begin
    res_hi = acc_q[63:32];
    res_lo = acc_q[31:0];
    if (op_q == OP_MULT) begin
      {res_hi, res_lo} = prod_neg_q ? (~acc_q + 64'd1) : acc_q;
    end else if (div0_q) begin
      res_hi = rs_q;
      res_lo = DIV0_LO;
    end else if (ovf_q) begin
      res_hi = 32'd0;
      res_lo = OVF_LO;
    end else begin
      res_lo = quo_neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
      res_hi = rem_neg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      op_q       <= OP_MULT;
      cnt_q      <= 6'd0;
      acc_q      <= 64'd0;
      operand_q  <= 32'd0;
      rs_q       <= 32'd0;
      prod_neg_q <= 1'b0;
      quo_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      div0_q     <= 1'b0;
      ovf_q      <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (accept) begin
            state_q    <= CALC;
            op_q       <= start_mult ? OP_MULT : OP_DIV;
            cnt_q      <= 6'd0;
            busy_q     <= 1'b1;
            rs_q       <= rs_val;
            // Multiply keeps the multiplier in the low half; divide the dividend.
            acc_q      <= start_mult ? {32'd0, md_mag(rt_val, is_signed)}
                                     : {32'd0, md_mag(rs_val, is_signed)};
            operand_q  <= start_mult ? md_mag(rs_val, is_signed)
                                     : md_mag(rt_val, is_signed);
            prod_neg_q <= is_signed && (rs_val[31] ^ rt_val[31]);
            quo_neg_q  <= is_signed && (rs_val[31] ^ rt_val[31]);
            rem_neg_q  <= is_signed && rs_val[31];
            div0_q     <= (rt_val == 32'd0);
            ovf_q      <= is_signed && (rs_val == 32'h8000_0000) &&
                          (rt_val == 32'hFFFF_FFFF);
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'(MD_ITER - 1)) state_q <= FIXUP;
        end
        FIXUP: begin
          hi_q    <= res_hi;
          lo_q    <= res_lo;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;
  assign stall     = busy_q & (mfhi_sel | mflo_sel | start_mult | start_div);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, signed/unsigned results, stall, reset abort.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_mult;
  logic        start_div;
  logic        is_signed;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mfhi_sel;
  logic        mflo_sel;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;
  logic        done;
  state_t      dbg_state;

  int err_cnt = 0;
  int chk_cnt = 0;
  logic [63:0] exp_q[$];

  muldiv_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_mult (start_mult),
    .start_div  (start_div),
    .is_signed  (is_signed),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .mfhi_sel   (mfhi_sel),
    .mflo_sel   (mflo_sel),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .stall      (stall),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // Clock and run watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: present one start for exactly one rising edge (edge N).
  task automatic issue(input logic m, input logic d, input logic sgn,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start_mult = m;
    start_div  = d;
    is_signed  = sgn;
    rs_val     = a;
    rt_val     = b;
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    start_div  = 1'b0;
  endtask

  // Scoreboard: wait for done, check latency and {hi,lo} against exp_q head.
  task automatic wait_done(input string tag);
    int lat = 0;
    logic [63:0] exp;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (c == 16) check({tag, " busy_mid"}, 64'(busy), 64'd1);
      if (done) begin
        lat = c;
        break;
      end
    end
    check({tag, " latency"}, 64'(lat), 64'd33);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    check({tag, " hilo"}, {hi, lo}, exp);
    @(posedge clk);
    #1;
    check({tag, " busy_clear"}, 64'(busy), 64'd0);
    check({tag, " done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int dcount;
    logic [31:0] old_lo;
    int lat;

    reset_n    = 1'b0;
    start_mult = 1'b1;
    start_div  = 1'b0;
    is_signed  = 1'b0;
    rs_val     = 32'd2;
    rt_val     = 32'd3;
    mfhi_sel   = 1'b0;
    mflo_sel   = 1'b0;

    // Reset with a start held high: nothing may be accepted.
    repeat (3) @(posedge clk);
    #1;
    check("rst hi", 64'(hi), 64'd0);
    check("rst lo", 64'(lo), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst state", 64'(dbg_state), 64'(IDLE));
    reset_n    = 1'b1;
    start_mult = 1'b0;
    @(posedge clk);
    #1;
    check("rst no_accept", 64'(busy), 64'd0);
    check("rst state_after", 64'(dbg_state), 64'(IDLE));

    issue(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    exp_q.push_back(64'hFFFF_FFFE_0000_0001);
    wait_done("multu_max");

    issue(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd7);
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFEB);
    wait_done("mult_neg3x7");

    issue(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFD);
    wait_done("div_neg7by2");

    issue(1'b0, 1'b1, 1'b0, 32'd5, 32'd0);
    exp_q.push_back(64'h0000_0005_FFFF_FFFF);
    wait_done("divu_by0");

    issue(1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    exp_q.push_back(64'h0000_0000_8000_0000);
    wait_done("div_ovf");

    issue(1'b0, 1'b1, 1'b0, 32'd100, 32'd7);
    exp_q.push_back(64'h0000_0002_0000_000E);
    wait_done("divu_100by7");

    // mflo_sel from cycle 10, ignored start_div at cycle 12, LO held until commit.
    old_lo = lo;
    issue(1'b1, 1'b0, 1'b1, 32'h0001_0000, 32'h0001_0000);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = c;
        break;
      end
      if (c >= 10) check($sformatf("mflo stall c%0d", c), 64'(stall), 64'd1);
      if (c == 20) check("mflo lo_held", 64'(lo), 64'(old_lo));
      if (c == 9) mflo_sel = 1'b1;
      if (c == 11) begin
        start_div = 1'b1;
        is_signed = 1'b0;
        rs_val    = 32'd9;
        rt_val    = 32'd2;
      end
      if (c == 12) start_div = 1'b0;
    end
    check("mflo latency", 64'(lat), 64'd33);
    check("mflo stall_at_done", 64'(stall), 64'd1);
    check("mflo hilo", {hi, lo}, 64'h0000_0001_0000_0000);
    @(posedge clk);
    #1;
    check("mflo stall_drop", 64'(stall), 64'd0);
    mflo_sel = 1'b0;
    dcount = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (done || busy) dcount++;
    end
    check("mflo start_ignored", 64'(dcount), 64'd0);

    issue(1'b1, 1'b1, 1'b0, 32'd6, 32'd3);
    exp_q.push_back(64'h0000_0000_0000_0012);
    wait_done("both_starts");

    // Reset in cycle 15 of a divide discards it.
    issue(1'b0, 1'b1, 1'b1, 32'd100, 32'd7);
    repeat (14) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort state", 64'(dbg_state), 64'(IDLE));
    check("abort hi", 64'(hi), 64'd0);
    check("abort lo", 64'(lo), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    reset_n = 1'b1;
    dcount = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    check("abort no_done", 64'(dcount), 64'd0);

    issue(1'b1, 1'b0, 1'b0, 32'd2, 32'd3);
    exp_q.push_back(64'h0000_0000_0000_0006);
    wait_done("mult_2x3");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
